ula_arbiter: RTL and testbench
==============================

Name: ula_arbiter

Overview:
- Shares the single registered ALU (one-cycle result latency, flags {minus, zero, carry}) between two requesters, e.g. core execute stage (port 0) and address/loop engine (port 1).
- Valid/ready request handshake per requester, round-robin grant, drives ALU operands/ctrl, tags the in-flight op.
- Routes each result plus flags into a per-requester 2-entry response buffer with its own valid/ready handshake.
- Issue rate up to one op per cycle overall.

Parameters:
- TAM, `TAM (32), operand/result width.
- CTRL_W, 4, ALU control width ({op[2:0], variant}).
- FLAG_W, 3, ALU flag width ({minus, zero, carry}).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 op pending.
- req0_ready  out  1  requester 0 op accepted this cycle.
- req0_a, req0_b  in  TAM  requester 0 operands.
- req0_ctrl  in  CTRL_W  requester 0 ALU control.
- rsp0_valid  out  1  requester 0 result available.
- rsp0_ready  in  1  requester 0 consumes result.
- rsp0_data  out  TAM  result.
- rsp0_flags  out  FLAG_W  flags.
- req1_*, rsp1_*  (same set for requester 1).
- ula_a, ula_b  out  TAM  ALU operand inputs.
- ula_ctrl  out  CTRL_W  ALU control.
- ula_out  in  TAM  ALU registered result.
- ula_flags  in  FLAG_W  ALU registered flags.
- busy  out  1  op in flight or any response buffer non-empty.

Behaviour:
- Reset (async, rst_n=0): all req*_ready=0, rsp*_valid=0, rsp*_data=0, rsp*_flags=0, ula_a/b/ctrl=0, busy=0. In-flight tag cleared, buffers emptied, last_grant=1 (requester 0 wins first tie). In-flight ops are dropped and never delivered.
- Eligibility: elig_i = req_i_valid & (occ_i + inflight_to_i) < 2, where occ_i is buffer occupancy (0..2) and inflight_to_i = inflight_v & (inflight_id==i).
- Grant (combinational): one eligible requester gets it; both eligible -> the one not equal to last_grant. req_i_ready = grant_i. Transfer when valid & ready.
- ula_a/b/ctrl are a combinational mux of the granted request's fields. With no grant they are driven to 0 and the ALU result next cycle is ignored.
- Cycle N (grant): at posedge end of N, inflight_v<=1, inflight_id<=i, last_grant<=i. The ALU captures operands on the same edge.
- Cycle N+1: ula_out/ula_flags are valid. If inflight_v, push {ula_out, ula_flags} into buffer[inflight_id] at the edge ending N+1. inflight_v<=new grant present.
- Latency: request accept to rsp_valid = 2 cycles. Back-to-back issue is allowed every cycle.
- Response buffer: 2-entry FIFO per requester. rsp_valid = occ>0; head drives rsp_data/flags; pop on rsp_valid & rsp_ready.
- Simultaneous push and pop: occupancy unchanged. This is legal at occ=1 or occ=2; the eligibility rule guarantees push never exceeds 2.
- Overflow is impossible by construction; assert-check push when occ==2 & no pop.
- Flags pass through unmodified, bit order {minus, zero, carry}.
- Order is preserved per requester. No ordering exists across requesters.
- Holding a request: req fields must stay stable while valid & ~ready. The block does not latch unaccepted requests.
- busy = inflight_v | (occ0!=0) | (occ1!=0).

Decomposition:
- Shared package/const include: `TAM, flag bit indices (FLG_MINUS=2, FLG_ZERO=1, FLG_CARRY=0), ALU op encodings (ADD/SUB 000x, AND/NAND 001x, OR 010, XOR 011, SHR/ROTR 100x, SRA 101, SHL 110, ROTL 111).
- One sub-module: ula_rsp_fifo. It is a 2-entry FIFO of width TAM+FLAG_W with push, pop, occ[1:0], head outputs and async active-low reset. It is instantiated twice.

Test Plan:
Bench pairs the DUT with the ALU or a cycle-accurate model.
- Single op: req0 AND, a=0xF0F0, b=0x0FF0, ctrl=4'b0010 at cycle 0 -> req0_ready=1 at cycle 0, rsp0_valid at cycle 2, data=0x000000F0, flags zero bit=0.
- Contention: req0 and req1 both valid for 4 cycles, rsp ready=1 -> grants 0,1,0,1. Each rsp receives its own results in order, 2-cycle latency.
- Backpressure: rsp0_ready=0 with req0 continuously valid -> exactly 2 accepts. req0_ready then stays 0. rsp0_valid=1 holds the first result. Raising rsp0_ready resumes one accept per pop.
- Full push+pop: occ0=1, op in flight to 0, rsp0_ready=1 -> same-cycle push/pop, occ stays 1, no data loss, next accept granted.
- Zero result: req1 XOR, a=b=0x12345678, ctrl=4'b0110 -> rsp1_data=0, flags zero bit=1.
- Reset mid-flight: assert rst_n=0 one cycle after accept -> all outputs 0 immediately (async). No rsp_valid after release. First post-reset tie grants requester 0.

Source files
------------

// File: rtl/ula_arbiter_pkg.sv
// rtl/ula_arbiter_pkg.sv - shared widths, flag indices and ALU op encodings for ula_arbiter
`ifndef TAM
`define TAM 32
`endif

package ula_arbiter_pkg;
  localparam int ULA_TAM    = `TAM;
  localparam int ULA_CTRL_W = 4;
  localparam int ULA_FLAG_W = 3;

  localparam int FLG_MINUS = 2;
  localparam int FLG_ZERO  = 1;
  localparam int FLG_CARRY = 0;

  // ctrl = {op, variant}; variant selects SUB/NAND/ROTR within a pair
  typedef enum logic [2:0] {
    OP_ADDSUB  = 3'b000,
    OP_ANDNAND = 3'b001,
    OP_OR      = 3'b010,
    OP_XOR     = 3'b011,
    OP_SHRROT  = 3'b100,
    OP_SRA     = 3'b101,
    OP_SHL     = 3'b110,
    OP_ROTL    = 3'b111
  } ula_op_e;
endpackage

// File: rtl/ula_arbiter_rsp_fifo.sv
// rtl/ula_arbiter_rsp_fifo.sv - 2-entry response FIFO holding {result, flags}
module ula_rsp_fifo
  import ula_arbiter_pkg::*;
#(
  parameter int W = ULA_TAM + ULA_FLAG_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [1:0]   o_occ,
  output logic [W-1:0] o_head
);
  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_occ;
  logic         w_pop;

  assign w_pop  = i_pop & (r_occ != 2'd0);
  assign o_occ  = r_occ;
  assign o_head = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Upstream eligibility reserves a slot per in-flight op, so a push into a full buffer is a bug
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && (r_occ == 2'd2) && !w_pop));
endmodule

// File: rtl/ula_arbiter.sv
// rtl/ula_arbiter.sv - round-robin sharing of one registered ALU between two requesters
module ula_arbiter
  import ula_arbiter_pkg::*;
#(
  parameter int TAM    = ULA_TAM,
  parameter int CTRL_W = ULA_CTRL_W,
  parameter int FLAG_W = ULA_FLAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [TAM-1:0]    req0_a,
  input  logic [TAM-1:0]    req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [TAM-1:0]    rsp0_data,
  output logic [FLAG_W-1:0] rsp0_flags,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [TAM-1:0]    req1_a,
  input  logic [TAM-1:0]    req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [TAM-1:0]    rsp1_data,
  output logic [FLAG_W-1:0] rsp1_flags,
  output logic [TAM-1:0]    ula_a,
  output logic [TAM-1:0]    ula_b,
  output logic [CTRL_W-1:0] ula_ctrl,
  input  logic [TAM-1:0]    ula_out,
  input  logic [FLAG_W-1:0] ula_flags,
  output logic              busy
);
  localparam int RW = TAM + FLAG_W;

  logic          r_inflight_v;
  logic          r_inflight_id;
  logic          r_last_grant;
  logic [1:0]    w_occ0, w_occ1;
  logic [1:0]    w_cnt0, w_cnt1;
  logic          w_elig0, w_elig1;
  logic          w_gnt0, w_gnt1;
  logic          w_push0, w_push1;
  logic [RW-1:0] w_head0, w_head1;

  // Buffer slots already committed: occupancy plus the op currently inside the ALU
  assign w_cnt0  = w_occ0 + {1'b0, r_inflight_v & ~r_inflight_id};
  assign w_cnt1  = w_occ1 + {1'b0, r_inflight_v &  r_inflight_id};
  assign w_elig0 = rst_n & req0_valid & (w_cnt0 < 2'd2);
  assign w_elig1 = rst_n & req1_valid & (w_cnt1 < 2'd2);
  assign w_gnt0  = w_elig0 & (~w_elig1 |  r_last_grant);
  assign w_gnt1  = w_elig1 & (~w_elig0 | ~r_last_grant);

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  always_comb begin
    ula_a    = '0;
    ula_b    = '0;
    ula_ctrl = '0;
    if (w_gnt0) begin
      ula_a    = req0_a;
      ula_b    = req0_b;
      ula_ctrl = req0_ctrl;
    end else if (w_gnt1) begin
      ula_a    = req1_a;
      ula_b    = req1_b;
      ula_ctrl = req1_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight_v  <= 1'b0;
      r_inflight_id <= 1'b0;
      r_last_grant  <= 1'b1;
    end else begin
      r_inflight_v <= w_gnt0 | w_gnt1;
      if (w_gnt0 | w_gnt1) begin
        r_inflight_id <= w_gnt1;
        r_last_grant  <= w_gnt1;
      end
    end
  end

  assign w_push0 = r_inflight_v & ~r_inflight_id;
  assign w_push1 = r_inflight_v &  r_inflight_id;

  ula_rsp_fifo #(.W(RW)) u_fifo0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push0),
    .i_data ({ula_out, ula_flags}),
    .i_pop  (rsp0_ready),
    .o_occ  (w_occ0),
    .o_head (w_head0)
  );

  ula_rsp_fifo #(.W(RW)) u_fifo1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push1),
    .i_data ({ula_out, ula_flags}),
    .i_pop  (rsp1_ready),
    .o_occ  (w_occ1),
    .o_head (w_head1)
  );

  assign rsp0_valid = (w_occ0 != 2'd0);
  assign rsp1_valid = (w_occ1 != 2'd0);
  assign {rsp0_data, rsp0_flags} = w_head0;
  assign {rsp1_data, rsp1_flags} = w_head1;

  assign busy = r_inflight_v | (w_occ0 != 2'd0) | (w_occ1 != 2'd0);
endmodule

// File: tb/tb_ula_arbiter.sv
// tb/tb_ula_arbiter.sv - scoreboard bench for ula_arbiter with a registered ALU model
module tb_ula_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp0_data, rsp1_data;
  logic [3:0]  req0_ctrl, req1_ctrl, ula_ctrl;
  logic [2:0]  rsp0_flags, rsp1_flags, ula_flags;
  logic [31:0] ula_a, ula_b, ula_out;
  logic        busy;

  ula_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data), .rsp0_flags(rsp0_flags),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data), .rsp1_flags(rsp1_flags),
    .ula_a(ula_a), .ula_b(ula_b), .ula_ctrl(ula_ctrl),
    .ula_out(ula_out), .ula_flags(ula_flags), .busy(busy)
  );

  function automatic logic [34:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    logic [32:0] s;
    case (c[3:1])
      3'b000:  s = c[0] ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
      3'b001:  s = {1'b0, c[0] ? ~(a & b) : (a & b)};
      3'b010:  s = {1'b0, a | b};
      3'b011:  s = {1'b0, a ^ b};
      default: s = '0;
    endcase
    return {s[31:0], s[31], (s[31:0] == 32'd0), s[32]};
  endfunction

  always @(posedge clk) {ula_out, ula_flags} <= alu(ula_a, ula_b, ula_ctrl);

  typedef struct {logic [31:0] a; logic [31:0] b; logic [3:0] ctrl; logic [31:0] d; logic [2:0] f; bit lat;} stim_t;
  typedef struct {logic [31:0] d; logic [2:0] f; int acc; bit lat;} exp_t;

  stim_t stim0[$], stim1[$];
  exp_t  exp0[$], exp1[$];
  exp_t  e0, e1;
  int    gnt_log[$];
  int    n_cmp = 0, n_err = 0, cyc = 0, acc0 = 0, acc1 = 0, a0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic stim_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                               input logic [31:0] d, input logic [2:0] f, input bit lat);
    stim_t s;
    s.a = a; s.b = b; s.ctrl = c; s.d = d; s.f = f; s.lat = lat;
    return s;
  endfunction

  initial begin
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_ctrl = 0;
    forever begin
      @(posedge clk); #1;
      if (stim0.size() > 0) begin
        req0_valid = 1; req0_a = stim0[0].a; req0_b = stim0[0].b; req0_ctrl = stim0[0].ctrl;
      end else begin
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_ctrl = 0;
      end
      @(negedge clk);
      if (req0_valid && req0_ready) begin
        exp0.push_back('{stim0[0].d, stim0[0].f, cyc, stim0[0].lat});
        void'(stim0.pop_front());
        acc0++;
        gnt_log.push_back(0);
      end
    end
  end

  initial begin
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_ctrl = 0;
    forever begin
      @(posedge clk); #1;
      if (stim1.size() > 0) begin
        req1_valid = 1; req1_a = stim1[0].a; req1_b = stim1[0].b; req1_ctrl = stim1[0].ctrl;
      end else begin
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_ctrl = 0;
      end
      @(negedge clk);
      if (req1_valid && req1_ready) begin
        exp1.push_back('{stim1[0].d, stim1[0].f, cyc, stim1[0].lat});
        void'(stim1.pop_front());
        acc1++;
        gnt_log.push_back(1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rsp0_valid && rsp0_ready) begin
      if (exp0.size() == 0) chk("rsp0_unexpected", 1, 0);
      else begin
        e0 = exp0.pop_front();
        chk("rsp0_data", rsp0_data, e0.d);
        chk("rsp0_flags", rsp0_flags, e0.f);
        if (e0.lat) chk("rsp0_latency", cyc - e0.acc, 2);
      end
    end
    if (rst_n && rsp1_valid && rsp1_ready) begin
      if (exp1.size() == 0) chk("rsp1_unexpected", 1, 0);
      else begin
        e1 = exp1.pop_front();
        chk("rsp1_data", rsp1_data, e1.d);
        chk("rsp1_flags", rsp1_flags, e1.f);
        if (e1.lat) chk("rsp1_latency", cyc - e1.acc, 2);
      end
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy && !req0_valid && !req1_valid && stim0.size() == 0 && stim1.size() == 0 &&
          exp0.size() == 0 && exp1.size() == 0) break;
    end
    if (k == 60) chk("idle_timeout", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (2) @(negedge clk);
    chk("reset_req0_ready", req0_ready, 0);
    chk("reset_req1_ready", req1_ready, 0);
    chk("reset_rsp0_valid", rsp0_valid, 0);
    chk("reset_rsp1_valid", rsp1_valid, 0);
    chk("reset_rsp0_data", rsp0_data, 0);
    chk("reset_rsp1_flags", rsp1_flags, 0);
    chk("reset_ula_a", ula_a, 0);
    chk("reset_ula_ctrl", ula_ctrl, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1;

    // contention from reset: tie goes to requester 0 first, then alternates
    @(negedge clk);
    gnt_log.delete();
    stim0.push_back(mk(32'd1, 32'd2, 4'b0000, 32'd3, 3'b000, 1));
    stim0.push_back(mk(32'd5, 32'd7, 4'b0001, 32'hFFFF_FFFE, 3'b100, 1));
    stim1.push_back(mk(32'hFFFF_FFFF, 32'd1, 4'b0000, 32'd0, 3'b011, 1));
    stim1.push_back(mk(32'h0000_0F00, 32'h0000_00F0, 4'b0100, 32'h0000_0FF0, 3'b000, 1));
    wait_idle();
    chk("contention_count", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("contention_grant", (i < gnt_log.size()) ? gnt_log[i] : 99, i % 2);

    // single AND on requester 0
    stim0.push_back(mk(32'h0000_F0F0, 32'h0000_0FF0, 4'b0010, 32'h0000_00F0, 3'b000, 1));
    @(posedge clk);
    @(negedge clk) chk("single_ready_c0", req0_ready, 1);
    @(negedge clk) chk("single_valid_c1", rsp0_valid, 0);
    @(negedge clk) chk("single_valid_c2", rsp0_valid, 1);
    wait_idle();

    // zero result on requester 1
    stim1.push_back(mk(32'h1234_5678, 32'h1234_5678, 4'b0110, 32'd0, 3'b010, 1));
    wait_idle();

    // backpressure on requester 0
    rsp0_ready = 0;
    a0 = acc0;
    for (int i = 1; i <= 4; i++)
      stim0.push_back(mk(32'd10, i, 4'b0000, 32'd10 + i, 3'b000, 0));
    repeat (6) @(negedge clk);
    chk("bp_accepts", acc0 - a0, 2);
    chk("bp_req0_ready", req0_ready, 0);
    chk("bp_rsp0_valid", rsp0_valid, 1);
    chk("bp_rsp0_head", rsp0_data, 32'd11);
    chk("bp_busy", busy, 1);
    @(posedge clk); #1 rsp0_ready = 1;
    wait_idle();
    chk("bp_total_accepts", acc0 - a0, 4);

    // same-cycle push and pop at occupancy 1
    rsp0_ready = 0;
    stim0.push_back(mk(32'h0000_0100, 32'h0000_0023, 4'b0000, 32'h0000_0123, 3'b000, 0));
    stim0.push_back(mk(32'hFF00_FF00, 32'hF0F0_F0F0, 4'b0010, 32'hF000_F000, 3'b100, 0));
    stim0.push_back(mk(32'hAAAA_5555, 32'h5555_AAAA, 4'b0110, 32'hFFFF_FFFF, 3'b100, 1));
    @(posedge clk);
    @(negedge clk) chk("pp_ready_c0", req0_ready, 1);
    @(negedge clk) chk("pp_ready_c1", req0_ready, 1);
    @(posedge clk); #1 rsp0_ready = 1;
    @(negedge clk);
    chk("pp_ready_c2", req0_ready, 0);
    chk("pp_valid_c2", rsp0_valid, 1);
    chk("pp_head_c2", rsp0_data, 32'h0000_0123);
    @(negedge clk);
    chk("pp_valid_c3", rsp0_valid, 1);
    chk("pp_head_c3", rsp0_data, 32'hF000_F000);
    chk("pp_ready_c3", req0_ready, 1);
    wait_idle();

    // reset one cycle after an accept drops the in-flight op
    stim0.push_back(mk(32'd7, 32'd8, 4'b0000, 32'd15, 3'b000, 1));
    @(posedge clk);
    @(negedge clk) chk("rst_accept", req0_ready, 1);
    @(posedge clk); #1 rst_n = 0;
    exp0.delete();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_ula_b", ula_b, 0);
    gnt_log.delete();
    stim0.push_back(mk(32'd2, 32'd2, 4'b0000, 32'd4, 3'b000, 1));
    stim1.push_back(mk(32'd1, 32'd3, 4'b0110, 32'd2, 3'b000, 1));
    @(posedge clk); #2;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_ula_a", ula_a, 0);
    @(posedge clk); #1 rst_n = 1;
    wait_idle();
    chk("rst_first_grant", (gnt_log.size() > 0) ? gnt_log[0] : 99, 0);
    chk("rst_second_grant", (gnt_log.size() > 1) ? gnt_log[1] : 99, 1);

    chk("end_exp0_empty", exp0.size(), 0);
    chk("end_exp1_empty", exp1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
